// File: rtl/armleocpu_defines_pkg.sv
// Constants shared by the TLB and the page table walker: TLB command encoding and PTE access-bit positions.
package armleocpu_defines_pkg;

   localparam logic [1:0] TLB_CMD_NONE           = 2'b00;
   localparam logic [1:0] TLB_CMD_RESOLVE        = 2'b01;
   localparam logic [1:0] TLB_CMD_WRITE          = 2'b10;
   localparam logic [1:0] TLB_CMD_INVALIDATE_ALL = 2'b11;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   localparam int VPN_W = 20;
   localparam int PPN_W = 22;

endpackage

// File: rtl/armleocpu_tlb_if.sv
// MMU <-> TLB command/response bundle; master is the MMU side, slave is the TLB.
interface armleocpu_tlb_if;
   import armleocpu_defines_pkg::*;

   logic [1:0]       cmd;
   logic [VPN_W-1:0] vpn;
   logic [7:0]       write_access_bits;
   logic [PPN_W-1:0] write_ppn;
   logic             resolve_done;
   logic             resolve_miss;
   logic [7:0]       resolve_access_bits;
   logic [PPN_W-1:0] resolve_ppn;
   logic             invalidate_done;
   logic [31:0]      hit_count;
   logic [31:0]      miss_count;

   modport master (
      output cmd, vpn, write_access_bits, write_ppn,
      input  resolve_done, resolve_miss, resolve_access_bits, resolve_ppn,
      input  invalidate_done, hit_count, miss_count
   );

   modport slave (
      input  cmd, vpn, write_access_bits, write_ppn,
      output resolve_done, resolve_miss, resolve_access_bits, resolve_ppn,
      output invalidate_done, hit_count, miss_count
   );

endinterface

// File: rtl/armleocpu_tlb_way.sv
// One TLB way: per-set valid flops (reset) plus tag/access/ppn arrays (not reset) behind one write port.
module armleocpu_tlb_way #(
   parameter int SET_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SET_BITS-1:0]   set_idx,
   input  logic [19-SET_BITS:0]  tag,
   input  logic                  write_en,
   input  logic                  invalidate,
   input  logic [7:0]            write_access,
   input  logic [21:0]           write_ppn,
   output logic                  valid,
   output logic                  hit,
   output logic [7:0]            access,
   output logic [21:0]           ppn
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = 20 - SET_BITS;

   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  valid_d;
   logic [TAG_W-1:0] tag_mem    [SETS];
   logic [7:0]       access_mem [SETS];
   logic [21:0]      ppn_mem    [SETS];

   always_comb begin
      valid_d = valid_q;
      if (invalidate) begin
         valid_d = '0;
      end else if (write_en) begin
         valid_d[set_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload arrays carry no reset; an entry is only meaningful while its valid flop is set.
   always_ff @(posedge clk) begin
      if (write_en) begin
         tag_mem[set_idx]    <= tag;
         access_mem[set_idx] <= write_access;
         ppn_mem[set_idx]    <= write_ppn;
      end
   end

   assign valid  = valid_q[set_idx];
   assign hit    = valid && (tag_mem[set_idx] == tag);
   assign access = access_mem[set_idx];
   assign ppn    = ppn_mem[set_idx];

endmodule

// File: rtl/armleocpu_tlb.sv
// Set-associative Sv32 TLB: combinational lookup, registered response, round-robin victim on full sets.
// Optional hit/miss statistics counters are built when ARMLEOCPU_TLB_STATS_EN is defined.
module armleocpu_tlb
   import armleocpu_defines_pkg::*;
#(
   parameter int SET_BITS = 2,
   parameter int WAY_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   armleocpu_tlb_if.slave  bus
);

   localparam int WAYS  = 1 << WAY_BITS;
   localparam int TAG_W = 20 - SET_BITS;

   logic [SET_BITS-1:0] set_idx;
   logic [TAG_W-1:0]    tag;

   logic [WAYS-1:0]     way_valid;
   logic [WAYS-1:0]     way_hit;
   logic [WAYS-1:0]     way_we;
   logic [7:0]          way_access [WAYS];
   logic [21:0]         way_ppn    [WAYS];

   logic                is_resolve;
   logic                is_invalidate;
   logic                write_fire;
   logic                any_hit;
   logic                any_free;
   logic [WAY_BITS-1:0] hit_way;
   logic [WAY_BITS-1:0] free_way;
   logic [WAY_BITS-1:0] write_way;

   logic                done_q,     done_d;
   logic                miss_q,     miss_d;
   logic [7:0]          access_q,   access_d;
   logic [21:0]         ppn_q,      ppn_d;
   logic                inv_done_q, inv_done_d;
   logic [WAY_BITS-1:0] victim_q,   victim_d;

   assign set_idx       = bus.vpn[SET_BITS-1:0];
   assign tag           = bus.vpn[19:SET_BITS];
   assign is_resolve    = (bus.cmd == TLB_CMD_RESOLVE);
   assign is_invalidate = (bus.cmd == TLB_CMD_INVALIDATE_ALL);
   assign write_fire    = (bus.cmd == TLB_CMD_WRITE) && bus.write_access_bits[PTE_V];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign way_we[gi] = write_fire && (write_way == WAY_BITS'(gi));

         armleocpu_tlb_way #(
            .SET_BITS (SET_BITS)
         ) u_way (
            .clk          (clk),
            .rst          (rst),
            .set_idx      (set_idx),
            .tag          (tag),
            .write_en     (way_we[gi]),
            .invalidate   (is_invalidate),
            .write_access (bus.write_access_bits),
            .write_ppn    (bus.write_ppn),
            .valid        (way_valid[gi]),
            .hit          (way_hit[gi]),
            .access       (way_access[gi]),
            .ppn          (way_ppn[gi])
         );
      end
   endgenerate

   // Scan from the top way down so the lowest-numbered match / free way wins.
   always_comb begin
      any_hit  = 1'b0;
      hit_way  = '0;
      any_free = 1'b0;
      free_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (way_hit[i]) begin
            any_hit = 1'b1;
            hit_way = WAY_BITS'(i);
         end
         if (!way_valid[i]) begin
            any_free = 1'b1;
            free_way = WAY_BITS'(i);
         end
      end
   end

   always_comb begin
      write_way  = victim_q;
      victim_d   = victim_q;
      done_d     = 1'b0;
      miss_d     = 1'b0;
      access_d   = '0;
      ppn_d      = '0;
      inv_done_d = is_invalidate;

      if (any_hit) begin
         write_way = hit_way;
      end else if (any_free) begin
         write_way = free_way;
      end else if (write_fire) begin
         victim_d = victim_q + WAY_BITS'(1);
      end

      if (is_resolve) begin
         done_d = 1'b1;
         miss_d = !any_hit;
         if (any_hit) begin
            access_d = way_access[hit_way];
            ppn_d    = way_ppn[hit_way];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q     <= 1'b0;
         miss_q     <= 1'b0;
         access_q   <= '0;
         ppn_q      <= '0;
         inv_done_q <= 1'b0;
         victim_q   <= '0;
      end else begin
         done_q     <= done_d;
         miss_q     <= miss_d;
         access_q   <= access_d;
         ppn_q      <= ppn_d;
         inv_done_q <= inv_done_d;
         victim_q   <= victim_d;
      end
   end

   assign bus.resolve_done        = done_q;
   assign bus.resolve_miss        = miss_q;
   assign bus.resolve_access_bits = access_q;
   assign bus.resolve_ppn         = ppn_q;
   assign bus.invalidate_done     = inv_done_q;

`ifdef ARMLEOCPU_TLB_STATS_EN
   logic [31:0] hit_count_q,  hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   // Counted together with the response register, so the count includes a result as soon as it is shown.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (done_d) begin
         if (miss_d) begin
            miss_count_d = miss_count_q + 32'd1;
         end else begin
            hit_count_d = hit_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign bus.hit_count  = hit_count_q;
   assign bus.miss_count = miss_count_q;
`else
   assign bus.hit_count  = '0;
   assign bus.miss_count = '0;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && is_resolve) begin
         assert ($onehot0(way_hit));
      end
   end
`endif

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Bench for armleocpu_tlb: directed vector table, random commands against an array-based model, reset corners.
module tb_armleocpu_tlb;
   import armleocpu_defines_pkg::*;

   localparam int SET_BITS = 2;
   localparam int WAY_BITS = 1;
   localparam int SETS     = 1 << SET_BITS;
   localparam int WAYS     = 1 << WAY_BITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   armleocpu_tlb_if bus ();

   armleocpu_tlb #(
      .SET_BITS (SET_BITS),
      .WAY_BITS (WAY_BITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int txn         = 0;

   // Reference model: a plain table of entries per set plus one global victim index.
   bit          m_valid [SETS][WAYS];
   int          m_tag   [SETS][WAYS];
   logic [7:0]  m_bits  [SETS][WAYS];
   logic [21:0] m_ppn   [SETS][WAYS];
   int          m_victim;
   int          m_hits;
   int          m_misses;

   typedef struct {
      logic [1:0]  cmd;
      logic [19:0] vpn;
      logic [7:0]  bits;
      logic [21:0] ppn;
      logic        e_done;
      logic        e_miss;
      logic [7:0]  e_bits;
      logic [21:0] e_ppn;
      logic        e_inv;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic ed, input logic em,
                            input logic [7:0] eb, input logic [21:0] ep, input logic ei);
      check({name, " done"},     32'(bus.resolve_done),        32'(ed));
      check({name, " miss"},     32'(bus.resolve_miss),        32'(em));
      check({name, " bits"},     32'(bus.resolve_access_bits), 32'(eb));
      check({name, " ppn"},      32'(bus.resolve_ppn),         32'(ep));
      check({name, " inv_done"}, 32'(bus.invalidate_done),     32'(ei));
   endtask

   task automatic m_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            m_valid[s][w] = 1'b0;
      m_victim = 0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic m_lookup(input logic [19:0] v, output logic miss,
                           output logic [7:0] b, output logic [21:0] p);
      int s;
      int t;
      s    = int'(v) % SETS;
      t    = int'(v) / SETS;
      miss = 1'b1;
      b    = '0;
      p    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (miss && m_valid[s][w] && m_tag[s][w] == t) begin
            miss = 1'b0;
            b    = m_bits[s][w];
            p    = m_ppn[s][w];
         end
      end
   endtask

   task automatic m_write(input logic [19:0] v, input logic [7:0] b, input logic [21:0] p);
      int s;
      int t;
      int w;
      s = int'(v) % SETS;
      t = int'(v) / SETS;
      w = -1;
      if (b[PTE_V]) begin
         for (int i = 0; i < WAYS; i++)
            if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
         for (int i = 0; i < WAYS; i++)
            if (w < 0 && !m_valid[s][i]) w = i;
         if (w < 0) begin
            w        = m_victim;
            m_victim = (m_victim + 1) % WAYS;
         end
         m_valid[s][w] = 1'b1;
         m_tag[s][w]   = t;
         m_bits[s][w]  = b;
         m_ppn[s][w]   = p;
      end
   endtask

   // Predicts the response from the model, updates the model, then issues the command for one edge.
   task automatic apply(input logic [1:0] c, input logic [19:0] v, input logic [7:0] b,
                        input logic [21:0] p, output logic ed, output logic em,
                        output logic [7:0] eb, output logic [21:0] ep, output logic ei);
      ed = 1'b0;
      em = 1'b0;
      eb = '0;
      ep = '0;
      ei = 1'b0;
      case (c)
         TLB_CMD_RESOLVE: begin
            ed = 1'b1;
            m_lookup(v, em, eb, ep);
            if (em) m_misses++;
            else    m_hits++;
         end
         TLB_CMD_WRITE: m_write(v, b, p);
         TLB_CMD_INVALIDATE_ALL: begin
            ei = 1'b1;
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++)
                  m_valid[s][w] = 1'b0;
         end
         default: ;
      endcase
      bus.cmd               = c;
      bus.vpn               = v;
      bus.write_access_bits = b;
      bus.write_ppn         = p;
      @(posedge clk);
      #1;
      $display("txn %0d cmd=%0d vpn=%05h done=%0b miss=%0b bits=%02h ppn=%06h inv=%0b",
               txn, c, v, bus.resolve_done, bus.resolve_miss, bus.resolve_access_bits,
               bus.resolve_ppn, bus.invalidate_done);
      txn++;
   endtask

   function automatic vec_t mk(input logic [1:0] c, input logic [19:0] v, input logic [7:0] b,
                               input logic [21:0] p, input logic ed, input logic em,
                               input logic [7:0] eb, input logic [21:0] ep, input logic ei);
      vec_t r;
      r.cmd = c;  r.vpn = v;     r.bits = b;    r.ppn = p;
      r.e_done = ed; r.e_miss = em; r.e_bits = eb; r.e_ppn = ep; r.e_inv = ei;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ed, em, ei;
      logic [7:0]  eb;
      logic [21:0] ep;
      logic [1:0]  c;
      logic [19:0] v;
      logic [7:0]  b;
      logic [21:0] p;
      int          r;

      localparam logic [1:0] R = TLB_CMD_RESOLVE;
      localparam logic [1:0] W = TLB_CMD_WRITE;
      localparam logic [1:0] I = TLB_CMD_INVALIDATE_ALL;

      tbl.push_back(mk(R, 20'h00401, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(W, 20'h00401, 8'hCF, 22'h000123, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00401, 8'h00, 22'h0,      1, 0, 8'hCF, 22'h000123, 0));
      tbl.push_back(mk(W, 20'h00004, 8'hCF, 22'h000004, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(W, 20'h00008, 8'hC7, 22'h000008, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(W, 20'h0000C, 8'h5F, 22'h00000C, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00004, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00008, 8'h00, 22'h0,      1, 0, 8'hC7, 22'h000008, 0));
      tbl.push_back(mk(R, 20'h0000C, 8'h00, 22'h0,      1, 0, 8'h5F, 22'h00000C, 0));
      tbl.push_back(mk(W, 20'h00002, 8'hCF, 22'h000001, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(W, 20'h00002, 8'hCF, 22'h000002, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00002, 8'h00, 22'h0,      1, 0, 8'hCF, 22'h000002, 0));
      tbl.push_back(mk(W, 20'h00006, 8'hD3, 22'h000006, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(W, 20'h0000A, 8'h8B, 22'h00000A, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00002, 8'h00, 22'h0,      1, 0, 8'hCF, 22'h000002, 0));
      tbl.push_back(mk(R, 20'h00006, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h0000A, 8'h00, 22'h0,      1, 0, 8'h8B, 22'h00000A, 0));
      tbl.push_back(mk(R, 20'h00401, 8'h00, 22'h0,      1, 0, 8'hCF, 22'h000123, 0));
      tbl.push_back(mk(I, 20'h00000, 8'h00, 22'h0,      0, 0, 8'h00, 22'h0,      1));
      tbl.push_back(mk(R, 20'h00401, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00008, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h0000C, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00002, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h0000A, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));
      tbl.push_back(mk(W, 20'h00005, 8'h0E, 22'h000055, 0, 0, 8'h00, 22'h0,      0));
      tbl.push_back(mk(R, 20'h00005, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0,      0));

      bus.cmd               = TLB_CMD_NONE;
      bus.vpn               = '0;
      bus.write_access_bits = '0;
      bus.write_ppn         = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check_out("reset", 1'b0, 1'b0, 8'h00, 22'h0, 1'b0);
      check("reset hit_count",  bus.hit_count,  32'd0);
      check("reset miss_count", bus.miss_count, 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].cmd, tbl[i].vpn, tbl[i].bits, tbl[i].ppn, ed, em, eb, ep, ei);
         check_out($sformatf("vec%0d", i), tbl[i].e_done, tbl[i].e_miss,
                   tbl[i].e_bits, tbl[i].e_ppn, tbl[i].e_inv);
      end

      apply(TLB_CMD_NONE, 20'h0, 8'h0, 22'h0, ed, em, eb, ep, ei);
      check_out("idle after table", 1'b0, 1'b0, 8'h00, 22'h0, 1'b0);
`ifdef ARMLEOCPU_TLB_STATS_EN
      check("table hit_count",  bus.hit_count,  32'd7);
      check("table miss_count", bus.miss_count, 32'd9);
`else
      check("table hit_count",  bus.hit_count,  32'd0);
      check("table miss_count", bus.miss_count, 32'd0);
`endif

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5)       c = TLB_CMD_RESOLVE;
         else if (r < 8)  c = TLB_CMD_WRITE;
         else if (r == 8) c = TLB_CMD_INVALIDATE_ALL;
         else             c = TLB_CMD_NONE;
         v    = 20'($urandom_range(0, 15));
         b    = 8'($urandom);
         b[0] = ($urandom_range(0, 5) != 0);
         p    = 22'($urandom);
         apply(c, v, b, p, ed, em, eb, ep, ei);
         check_out($sformatf("rand%0d", n), ed, em, eb, ep, ei);
      end

      apply(TLB_CMD_NONE, 20'h0, 8'h0, 22'h0, ed, em, eb, ep, ei);
`ifdef ARMLEOCPU_TLB_STATS_EN
      check("rand hit_count",  bus.hit_count,  32'(m_hits));
      check("rand miss_count", bus.miss_count, 32'(m_misses));
`else
      check("rand hit_count",  bus.hit_count,  32'd0);
      check("rand miss_count", bus.miss_count, 32'd0);
`endif

      // Reset on the same edge as a RESOLVE must swallow the response and drop the fresh entry.
      apply(TLB_CMD_WRITE, 20'h00007, 8'hCF, 22'h000777, ed, em, eb, ep, ei);
      bus.cmd = TLB_CMD_RESOLVE;
      bus.vpn = 20'h00007;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      check_out("rst during resolve", 1'b0, 1'b0, 8'h00, 22'h0, 1'b0);
      check("rst hit_count",  bus.hit_count,  32'd0);
      check("rst miss_count", bus.miss_count, 32'd0);
      apply(TLB_CMD_RESOLVE, 20'h00007, 8'h0, 22'h0, ed, em, eb, ep, ei);
      check_out("resolve after rst", 1'b1, 1'b1, 8'h00, 22'h0, 1'b0);

      bus.cmd = TLB_CMD_INVALIDATE_ALL;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      check_out("rst during invalidate", 1'b0, 1'b0, 8'h00, 22'h0, 1'b0);

      // After reset the victim restarts at way 0: third write in set 3 evicts the first.
      apply(TLB_CMD_WRITE,   20'h00003, 8'h01, 22'h000003, ed, em, eb, ep, ei);
      apply(TLB_CMD_WRITE,   20'h00007, 8'h03, 22'h000007, ed, em, eb, ep, ei);
      apply(TLB_CMD_WRITE,   20'h0000B, 8'h05, 22'h00000B, ed, em, eb, ep, ei);
      apply(TLB_CMD_RESOLVE, 20'h00003, 8'h0,  22'h0,      ed, em, eb, ep, ei);
      check_out("victim after rst a", 1'b1, 1'b1, 8'h00, 22'h0, 1'b0);
      apply(TLB_CMD_RESOLVE, 20'h00007, 8'h0,  22'h0,      ed, em, eb, ep, ei);
      check_out("victim after rst b", 1'b1, 1'b0, 8'h03, 22'h000007, 1'b0);
      apply(TLB_CMD_RESOLVE, 20'h0000B, 8'h0,  22'h0,      ed, em, eb, ep, ei);
      check_out("victim after rst c", 1'b1, 1'b0, 8'h05, 22'h00000B, 1'b0);
      apply(TLB_CMD_NONE,    20'h0,     8'h0,  22'h0,      ed, em, eb, ep, ei);
      check_out("final idle", 1'b0, 1'b0, 8'h00, 22'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
